fp_share_arbiter: RTL and testbench
===================================

Name: fp_share_arbiter

Overview:
- Responder side of the valid/ready/finish FP-operator handshake used by CMU compute blocks.
- Presents NREQ independent responder ports and funnels them onto one shared, non-pipelined FP unit (fp_multiplier or fp_adder) through a single initiator port.
- Lets several CMU FSMs share one double-precision operator instead of each instantiating its own.
- Results are routed back to the originating port with a one-cycle finish pulse.

Parameters:
- DBL_WIDTH, 64, operand/result width (IEEE-754 double; block treats data as opaque bits).
- NREQ, 4, number of responder ports (2..8).
- TIMEOUT, 255, max cycles to wait for downstream finish before flagging error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-port start pulse; a/b valid in the same cycle.
- req_a  in  NREQ*DBL_WIDTH  port i operand A at bits [i*DBL_WIDTH +: DBL_WIDTH].
- req_b  in  NREQ*DBL_WIDTH  port i operand B, same packing.
- req_ready  out  NREQ  port i can accept a request.
- req_finish  out  NREQ  one-cycle pulse; port i result valid.
- req_result  out  NREQ*DBL_WIDTH  per-port result, held until the next finish on that port.
- fu_valid  out  1  start pulse to the shared FP unit.
- fu_a, fu_b  out  DBL_WIDTH  operands to the FP unit; stable from the fu_valid cycle until fu_finish.
- fu_ready  in  1  FP unit idle.
- fu_finish  in  1  FP unit result pulse.
- fu_result  in  DBL_WIDTH  FP unit result; sampled only when fu_finish is high.
- err  out  3  sticky flags: [0] overrun, [1] spurious fu_finish, [2] timeout.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears the following:
  - all slots empty;
  - state IDLE;
  - rr pointer 0;
  - outputs: req_finish=0, req_result=0, fu_valid=0, fu_a=fu_b=0, err=0.
  - req_ready becomes all-ones after reset, since all slots are empty.
- Reset mid-operation drops all pending and in-flight work. No req_finish is generated for it. A later fu_finish from the stale op is treated as spurious.
- Per-port pending slot (1-deep):
  - req_ready[i] = !slot_full[i], combinational.
  - req_valid[i] && req_ready[i] captures a/b into slot i; slot_full[i] is set at that edge.
  - req_valid[i] while slot_full[i]: request ignored, err[0] set.
  - Simultaneous valids on several ports: all captured in the same cycle.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if any slot is full and not yet issued, and fu_ready=1, select a winner by round-robin starting at rr_ptr. Load fu_a/fu_b from the winner's slot, latch the owner index, go to ISSUE.
  - ISSUE: fu_valid=1 for exactly this one cycle. Clear the timeout counter, go to WAIT.
  - WAIT: on fu_finish, write req_result[owner]=fu_result, pulse req_finish[owner] on the next cycle (registered), clear slot_full[owner] on the same edge, set rr_ptr=owner+1 mod NREQ, go to IDLE.
  - WAIT timeout: the counter increments each WAIT cycle. Reaching TIMEOUT without fu_finish sets err[2], clears the owner slot without a finish pulse, and returns to IDLE.
- fu_finish in IDLE or ISSUE: ignored, err[1] set.
- Only one downstream operation is outstanding at a time.
- Latency:
  - req_valid at cycle 0 → fu_valid at cycle 2 at the earliest (cycle 1 IDLE arbitration, cycle 2 ISSUE).
  - fu_finish at cycle k → req_finish at k+1.
  - req_ready[owner] is high in the same cycle as req_finish[owner], so a requester may issue back-to-back on its finish cycle.
- A newly captured request is not eligible for arbitration until the cycle after capture.
- No data modification: results pass bit-exact.

Decomposition:
- Package fp_share_pkg holds:
  - the state enum type (IDLE, ISSUE, WAIT, 2-bit);
  - err bit index constants (ERR_OVERRUN=0, ERR_SPURIOUS=1, ERR_TIMEOUT=2);
  - a function computing clog2(NREQ) for the owner/pointer width.
- One sub-module, rr_arbiter:
  - parameter NREQ;
  - inputs req vector and ptr;
  - outputs one-hot grant and binary index;
  - purely combinational.
- The top level keeps slots, FSM, counters and routing.

Test Plan:
- Single request: port 1 sends a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0); downstream multiplier model latency 5. Required: fu_valid at cycle 2 with those operands; req_finish[1] at cycle 8; req_result[1]=0x4018000000000000 (6.0); other ports untouched; err=0.
- Simultaneous: ports 0, 2, 3 pulse valid in one cycle. Required: service order 0, 2, 3, with rr_ptr starting at 0. Each port receives its own product. Exactly one fu_valid per operation, never overlapping.
- Fairness: port 0 re-requests on every finish cycle while port 1 is pending. Required: grants alternate 0, 1, 0, 1.
- Overrun: port 2 pulses valid twice before its finish. Required: second request dropped, err=3'b001, first result delivered unchanged.
- Timeout/spurious (TIMEOUT=10): downstream model never finishes. Required: err[2] set after 10 WAIT cycles, slot freed, req_ready high again. A later injected fu_finish in IDLE sets err[1].
- Reset mid-op: assert rst during WAIT. Required: next cycle all outputs zero and req_ready all-ones. The stale fu_finish produces no req_finish and sets err[1].

Source files
------------

// File: rtl/fp_share_pkg.sv
// Shared types and constants for the FP-operator share arbiter.
package fp_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int ERR_OVERRUN  = 0;
    localparam int ERR_SPURIOUS = 1;
    localparam int ERR_TIMEOUT  = 2;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fp_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_arbiter
    import fp_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] rot;
    logic [IW:0]     sum;

    // rot[k] is req[(ptr + k) mod NREQ]; the lowest set k wins.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        grant = '0;
        idx   = '0;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (IW + 1)'(k);
                idx = (sum >= (IW + 1)'(NREQ)) ? IW'(sum - (IW + 1)'(NREQ)) : IW'(sum);
            end
        end
        if (|req) grant = NREQ'(1) << idx;
    end

endmodule

// File: rtl/fp_share_arbiter.sv
// Shares one non-pipelined FP unit between NREQ valid/ready/finish requesters:
// one pending slot per port, round-robin issue, result routed back to its owner.
module fp_share_arbiter
    import fp_share_pkg::*;
#(
    parameter int DBL_WIDTH = 64,
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DBL_WIDTH-1:0] req_a,
    input  logic [NREQ*DBL_WIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           req_finish,
    output logic [NREQ*DBL_WIDTH-1:0] req_result,
    output logic                      fu_valid,
    output logic [DBL_WIDTH-1:0]      fu_a,
    output logic [DBL_WIDTH-1:0]      fu_b,
    input  logic                      fu_ready,
    input  logic                      fu_finish,
    input  logic [DBL_WIDTH-1:0]      fu_result,
    output logic [2:0]                err
);

    // state | meaning
    // IDLE  | wait for a full slot and an idle FP unit, then arbitrate
    // ISSUE | fu_valid high for this single cycle with the winner's operands
    // WAIT  | wait for fu_finish, bounded by the timeout down-counter

    localparam int IW = idx_width(NREQ);
    localparam int TW = idx_width(TIMEOUT);

    state_t                 state;
    logic [NREQ-1:0]        slot_full;
    logic [DBL_WIDTH-1:0]   slot_a [NREQ];
    logic [DBL_WIDTH-1:0]   slot_b [NREQ];
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          owner;
    logic [TW-1:0]          tmr;
    logic [NREQ-1:0]        grant;
    logic [IW-1:0]          win_idx;

    assign req_ready = ~slot_full;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (slot_full),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !slot_full[i]) begin
                slot_a[i] <= req_a[i*DBL_WIDTH +: DBL_WIDTH];
                slot_b[i] <= req_b[i*DBL_WIDTH +: DBL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot_full  <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            tmr        <= '0;
            req_finish <= '0;
            req_result <= '0;
            fu_valid   <= 1'b0;
            fu_a       <= '0;
            fu_b       <= '0;
            err        <= '0;
        end else begin
            req_finish <= '0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    if (slot_full[i]) err[ERR_OVERRUN] <= 1'b1;
                    else              slot_full[i]     <= 1'b1;
                end
            end
            // Owner-slot clears below come after the capture loop and win.
            case (state)
                IDLE: begin
                    if (fu_finish) err[ERR_SPURIOUS] <= 1'b1;
                    if ((|grant) && fu_ready) begin
                        fu_a     <= slot_a[win_idx];
                        fu_b     <= slot_b[win_idx];
                        owner    <= win_idx;
                        fu_valid <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fu_finish) err[ERR_SPURIOUS] <= 1'b1;
                    fu_valid <= 1'b0;
                    tmr      <= TW'(TIMEOUT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (fu_finish) begin
                        for (int i = 0; i < NREQ; i++) begin
                            if (owner == IW'(i)) req_result[i*DBL_WIDTH +: DBL_WIDTH] <= fu_result;
                        end
                        req_finish[owner] <= 1'b1;
                        slot_full[owner]  <= 1'b0;
                        rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end else if (tmr == '0) begin
                        err[ERR_TIMEOUT] <= 1'b1;
                        slot_full[owner] <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_share_arbiter.sv
// Bench for fp_share_arbiter: behavioural FP multiplier on the initiator side,
// round-robin order and result routing predicted from the arbitration rules.
module tb_fp_share_arbiter;

    localparam int DW = 64;
    localparam int N  = 4;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_finish;
    logic [N*DW-1:0] req_result;
    logic            fu_valid;
    logic [DW-1:0]   fu_a;
    logic [DW-1:0]   fu_b;
    logic            fu_ready = 1'b1;
    logic            fu_finish = 1'b0;
    logic [DW-1:0]   fu_result = '0;
    logic [2:0]      err;

    int total = 0;
    int bad   = 0;

    int            ptr_model = 0;
    logic [DW-1:0] exp_res [N];
    logic [DW-1:0] held    [N];

    bit            hang = 1'b0;
    bit            inject = 1'b0;
    int            fu_lat = 5;
    int            fu_cnt = 0;
    bit            fu_busy = 1'b0;
    int            fu_issues = 0;
    int            fu_overlaps = 0;
    logic [DW-1:0] pend_res = '0;

    fp_share_arbiter #(.DBL_WIDTH(DW), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .req_finish (req_finish),
        .req_result (req_result),
        .fu_valid   (fu_valid),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_ready   (fu_ready),
        .fu_finish  (fu_finish),
        .fu_result  (fu_result),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mul_bits(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [DW-1:0] rand_op();
        int v;
        v = $urandom_range(1, 4000);
        return $realtobits($itor(v));
    endfunction

    // Downstream non-pipelined multiplier with per-op latency (fu_lat=0 picks 1..8).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fu_finish = 1'b0;
            if (inject) begin
                fu_finish = 1'b1;
                fu_result = 64'hDEAD_BEEF_0BAD_F00D;
                inject    = 1'b0;
            end
            if (fu_busy) begin
                fu_cnt--;
                if (fu_cnt == 0) begin
                    fu_finish = 1'b1;
                    fu_result = pend_res;
                    fu_busy   = 1'b0;
                end
            end
            if (fu_valid) begin
                fu_issues++;
                if (fu_busy) fu_overlaps++;
                if (!hang) begin
                    fu_busy  = 1'b1;
                    fu_cnt   = (fu_lat == 0) ? int'($urandom_range(1, 8)) : fu_lat;
                    pend_res = mul_bits(fu_a, fu_b);
                end
            end
            fu_ready = !fu_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ptr_model = 0;
        for (int i = 0; i < N; i++) held[i] = '0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL reset_ready: got %h want f", req_ready); end
        total++; if (req_finish !== 4'h0) begin bad++; $display("FAIL reset_finish: got %h want 0", req_finish); end
        total++; if (req_result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", req_result); end
        total++; if (fu_valid !== 1'b0) begin bad++; $display("FAIL reset_fu_valid: got %b want 0", fu_valid); end
        total++; if ({fu_a, fu_b} !== '0) begin bad++; $display("FAIL reset_fu_ops: got %h %h want 0", fu_a, fu_b); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err); end
        rst = 1'b0;
        ptr_model = 0;
        for (int i = 0; i < N; i++) held[i] = '0;
    endtask

    task automatic test_single();
        logic [DW-1:0] a, b, r;
        int fin;
        a = 64'h4000_0000_0000_0000;
        b = 64'h4008_0000_0000_0000;
        r = 64'h4018_0000_0000_0000;
        do_reset();
        fu_lat = 5;
        req_a[1*DW +: DW] = a;
        req_b[1*DW +: DW] = b;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        total++; if (fu_valid !== 1'b0) begin bad++; $display("FAIL single_c1_valid: got %b want 0", fu_valid); end
        step();
        total++; if (fu_valid !== 1'b1) begin bad++; $display("FAIL single_c2_valid: got %b want 1", fu_valid); end
        total++; if (fu_a !== a || fu_b !== b) begin bad++; $display("FAIL single_ops: got %h %h want %h %h", fu_a, fu_b, a, b); end
        fin = -1;
        for (int c = 3; c <= 30; c++) begin
            step();
            if (req_finish !== '0) begin fin = c; break; end
        end
        total++; if (fin != 8) begin bad++; $display("FAIL single_finish_cycle: got %0d want 8", fin); end
        total++; if (req_finish !== 4'b0010) begin bad++; $display("FAIL single_finish_port: got %b want 0010", req_finish); end
        total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL single_ready_on_finish: got %b want 1", req_ready[1]); end
        total++; if (req_result[1*DW +: DW] !== mul_bits(a, b) || req_result[1*DW +: DW] !== r)
            begin bad++; $display("FAIL single_result: got %h want %h", req_result[1*DW +: DW], r); end
        total++; if (req_result !== {64'h0, 64'h0, r, 64'h0})
            begin bad++; $display("FAIL single_other_ports: got %h", req_result); end
        step();
        total++; if (req_finish !== 4'b0000) begin bad++; $display("FAIL single_pulse_width: got %b want 0000", req_finish); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL single_err: got %b want 000", err); end
    endtask

    task automatic test_simultaneous_random();
        int order[$];
        logic [N-1:0] mask, m;
        logic [DW-1:0] a, b;
        int p, n, done, iss0;
        do_reset();
        for (int bt = 0; bt < 12; bt++) begin
            mask   = (bt == 0) ? 4'b1101 : 4'($urandom_range(1, 15));
            fu_lat = (bt == 0) ? 5 : 0;
            order.delete();
            m = mask;
            p = ptr_model;
            n = 0;
            while (m != '0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (p + k) % N;
                    if (m[idx]) begin
                        order.push_back(idx);
                        m[idx] = 1'b0;
                        p = (idx + 1) % N;
                        n++;
                        break;
                    end
                end
            end
            ptr_model = p;
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    a = rand_op();
                    b = rand_op();
                    req_a[i*DW +: DW] = a;
                    req_b[i*DW +: DW] = b;
                    exp_res[i] = mul_bits(a, b);
                end
            end
            iss0 = fu_issues;
            req_valid = mask;
            step();
            req_valid = '0;
            done = 0;
            for (int c = 0; c < 300 && done < n; c++) begin
                step();
                if (req_finish !== '0) begin
                    total++; if (req_finish !== (4'b0001 << order[done]))
                        begin bad++; $display("FAIL rr_order: batch %0d got %b want port %0d", bt, req_finish, order[done]); end
                    held[order[done]] = exp_res[order[done]];
                    total++; if (req_result !== {held[3], held[2], held[1], held[0]})
                        begin bad++; $display("FAIL rr_route: batch %0d got %h", bt, req_result); end
                    done++;
                end
            end
            total++; if (done != n) begin bad++; $display("FAIL rr_done: batch %0d got %0d want %0d", bt, done, n); end
            total++; if (fu_issues - iss0 != n) begin bad++; $display("FAIL rr_issues: batch %0d got %0d want %0d", bt, fu_issues - iss0, n); end
        end
        total++; if (fu_overlaps != 0) begin bad++; $display("FAIL rr_overlap: got %0d want 0", fu_overlaps); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL rr_err: got %b want 000", err); end
    endtask

    task automatic test_fairness();
        int nfin, want;
        int sent [2];
        logic [DW-1:0] a, b;
        do_reset();
        fu_lat = 0;
        a = rand_op(); b = rand_op();
        req_a[0 +: DW] = a; req_b[0 +: DW] = b; exp_res[0] = mul_bits(a, b);
        req_valid = 4'b0001;
        step();
        a = rand_op(); b = rand_op();
        req_a[DW +: DW] = a; req_b[DW +: DW] = b; exp_res[1] = mul_bits(a, b);
        req_valid = 4'b0010;
        sent[0] = 1;
        sent[1] = 1;
        nfin = 0;
        for (int c = 0; c < 400 && nfin < 6; c++) begin
            step();
            req_valid = '0;
            if (req_finish !== '0) begin
                want = nfin % 2;
                total++; if (req_finish !== (4'b0001 << want))
                    begin bad++; $display("FAIL fair_grant: finish %0d got %b want port %0d", nfin, req_finish, want); end
                total++; if (req_ready[want] !== 1'b1)
                    begin bad++; $display("FAIL fair_ready: finish %0d got %b want 1", nfin, req_ready[want]); end
                total++; if (req_result[want*DW +: DW] !== exp_res[want])
                    begin bad++; $display("FAIL fair_result: finish %0d got %h want %h", nfin, req_result[want*DW +: DW], exp_res[want]); end
                nfin++;
                for (int i = 0; i < 2; i++) begin
                    if (req_finish[i] && sent[i] < 3) begin
                        a = rand_op(); b = rand_op();
                        req_a[i*DW +: DW] = a; req_b[i*DW +: DW] = b; exp_res[i] = mul_bits(a, b);
                        req_valid[i] = 1'b1;
                        sent[i]++;
                    end
                end
            end
        end
        req_valid = '0;
        total++; if (nfin != 6) begin bad++; $display("FAIL fair_count: got %0d want 6", nfin); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL fair_err: got %b want 000", err); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] a1, b1, a2, b2;
        int iss0, fin;
        do_reset();
        fu_lat = 5;
        a1 = rand_op(); b1 = rand_op();
        a2 = rand_op(); b2 = rand_op();
        iss0 = fu_issues;
        req_a[2*DW +: DW] = a1; req_b[2*DW +: DW] = b1;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        total++; if (err !== 3'b000) begin bad++; $display("FAIL ovr_err_before: got %b want 000", err); end
        step();
        step();
        req_a[2*DW +: DW] = a2; req_b[2*DW +: DW] = b2;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        total++; if (err !== 3'b001) begin bad++; $display("FAIL ovr_err_flag: got %b want 001", err); end
        fin = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (req_finish !== '0) begin fin = 1; break; end
        end
        total++; if (fin != 1 || req_finish !== 4'b0100) begin bad++; $display("FAIL ovr_finish: got %b want 0100", req_finish); end
        total++; if (req_result[2*DW +: DW] !== mul_bits(a1, b1))
            begin bad++; $display("FAIL ovr_result: got %h want %h", req_result[2*DW +: DW], mul_bits(a1, b1)); end
        for (int c = 0; c < 10; c++) step();
        total++; if (fu_issues - iss0 != 1) begin bad++; $display("FAIL ovr_dropped: got %0d issues want 1", fu_issues - iss0); end
        total++; if (err !== 3'b001) begin bad++; $display("FAIL ovr_err_after: got %b want 001", err); end
    endtask

    task automatic test_timeout();
        bit anyfin;
        do_reset();
        hang = 1'b1;
        anyfin = 1'b0;
        req_a[3*DW +: DW] = rand_op(); req_b[3*DW +: DW] = rand_op();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        for (int c = 2; c <= 12; c++) begin
            step();
            if (req_finish !== '0) anyfin = 1'b1;
        end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL to_early: got %b want 000", err); end
        total++; if (req_ready[3] !== 1'b0) begin bad++; $display("FAIL to_busy: got %b want 0", req_ready[3]); end
        step();
        if (req_finish !== '0) anyfin = 1'b1;
        total++; if (err !== 3'b100) begin bad++; $display("FAIL to_flag: got %b want 100", err); end
        total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL to_freed: got %h want f", req_ready); end
        hang = 1'b0;
        inject = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (req_finish !== '0) anyfin = 1'b1;
        end
        total++; if (err !== 3'b110) begin bad++; $display("FAIL to_spurious: got %b want 110", err); end
        total++; if (anyfin !== 1'b0) begin bad++; $display("FAIL to_no_finish: got %b want 0", anyfin); end
        total++; if (req_result !== '0) begin bad++; $display("FAIL to_result: got %h want 0", req_result); end
    endtask

    task automatic test_reset_midop();
        bit anyfin;
        do_reset();
        fu_lat = 5;
        anyfin = 1'b0;
        req_a[0 +: DW] = rand_op(); req_b[0 +: DW] = rand_op();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        for (int c = 1; c <= 4; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL rmid_ready: got %h want f", req_ready); end
        total++; if (fu_valid !== 1'b0 || {fu_a, fu_b} !== '0)
            begin bad++; $display("FAIL rmid_fu: got %b %h %h want 0", fu_valid, fu_a, fu_b); end
        total++; if (req_finish !== '0 || req_result !== '0 || err !== 3'b000)
            begin bad++; $display("FAIL rmid_outputs: got %b %h %b want 0", req_finish, req_result, err); end
        for (int c = 6; c <= 12; c++) begin
            step();
            if (req_finish !== '0) anyfin = 1'b1;
        end
        total++; if (anyfin !== 1'b0) begin bad++; $display("FAIL rmid_no_finish: got %b want 0", anyfin); end
        total++; if (err !== 3'b010) begin bad++; $display("FAIL rmid_spurious: got %b want 010", err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous_random();
        test_fairness();
        test_overrun();
        test_timeout();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
